// File: rtl/mpsoc_noc_switch_allocator.sv
// Per-output-port switch allocator: packet-granular round-robin arbitration
// over CHANNELS requesters feeding a single-entry output register.
module mpsoc_noc_switch_allocator #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 7
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  in_flit,
  input  logic [CHANNELS-1:0]                  in_last,
  input  logic [CHANNELS-1:0]                  in_valid,
  output logic [CHANNELS-1:0]                  in_ready,
  output logic [FLIT_WIDTH-1:0]                out_flit,
  output logic                                 out_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [CHANNELS-1:0]                  grant,
  output logic                                 locked
);

  localparam int IDXW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  function automatic logic [CHANNELS-1:0] onehot(input logic [IDXW-1:0] idx);
    logic [CHANNELS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  state_t                  r_state;
  logic [IDXW-1:0]         r_ptr;
  logic [IDXW-1:0]         r_owner;
  logic [CHANNELS-1:0]     r_grant;
  logic [FLIT_WIDTH-1:0]   r_out_flit;
  logic                    r_out_last;
  logic                    r_out_valid;

  logic [IDXW:0]           w_idx;
  logic [IDXW-1:0]         w_cand;
  logic                    w_found;
  logic                    w_hit;
  logic [IDXW-1:0]         w_sel;
  logic                    w_elig;
  logic                    w_load;
  logic [CHANNELS-1:0]     w_ready;
  logic                    w_xfer;
  logic [FLIT_WIDTH-1:0]   w_sel_flit;
  logic                    w_sel_last;

  // Round-robin search from ptr+1; the wide index keeps the wrap in range for any CHANNELS.
  always_comb begin
    w_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    w_hit   = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      w_idx   = {1'b0, r_ptr} + (IDXW+1)'(k);
      w_idx   = (w_idx >= (IDXW+1)'(CHANNELS)) ? (w_idx - (IDXW+1)'(CHANNELS)) : w_idx;
      w_hit   = !w_found && in_valid[w_idx[IDXW-1:0]];
      w_cand  = w_hit ? w_idx[IDXW-1:0] : w_cand;
      w_found = w_found | w_hit;
    end
  end

  // Handshake: only the owner (LOCKED) or the candidate (IDLE) may see ready.
  always_comb begin
    w_load = !r_out_valid || out_ready;
    if (r_state == S_LOCKED) begin
      w_sel  = r_owner;
      w_elig = 1'b1;
    end else begin
      w_sel  = w_cand;
      w_elig = w_found;
    end
    w_ready    = (w_load && w_elig && rst) ? onehot(w_sel) : {CHANNELS{1'b0}};
    w_xfer     = |(in_valid & w_ready);
    w_sel_flit = in_flit[w_sel];
    w_sel_last = in_last[w_sel];
  end

  // Arbitration FSM with round-robin pointer, owner and registered grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= IDXW'(CHANNELS-1);
      r_owner <= '0;
      r_grant <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            if (w_sel_last) begin
              r_ptr <= w_sel;
            end else begin
              r_state <= S_LOCKED;
              r_owner <= w_sel;
              r_grant <= onehot(w_sel);
            end
          end
        end
        S_LOCKED: begin
          if (w_xfer && w_sel_last) begin
            r_state <= S_IDLE;
            r_ptr   <= r_owner;
            r_grant <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  // Single-entry output pipeline register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_flit  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_out_flit  <= w_sel_flit;
        r_out_last  <= w_sel_last;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_ready;
  assign out_flit  = r_out_flit;
  assign out_last  = r_out_last;
  assign out_valid = r_out_valid;
  assign grant     = r_grant;
  assign locked    = (r_state == S_LOCKED);

endmodule

// File: tb/tb_mpsoc_noc_switch_allocator.sv
// Randomized bench for mpsoc_noc_switch_allocator: a behavioural arbitration
// model predicts handshakes and pushes expected flits; a monitor pops and compares.
module tb_mpsoc_noc_switch_allocator;

  localparam int FW = 32;
  localparam int CH = 7;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [CH-1:0][FW-1:0]   in_flit;
  logic [CH-1:0]           in_last;
  logic [CH-1:0]           in_valid;
  logic [CH-1:0]           in_ready;
  logic [FW-1:0]           out_flit;
  logic                    out_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [CH-1:0]           grant;
  logic                    locked;

  always #5 clk = ~clk;

  mpsoc_noc_switch_allocator #(.FLIT_WIDTH(FW), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst),
    .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .grant(grant), .locked(locked)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [FW:0] exp_q[$];

  // reference model state
  bit m_locked;
  int m_owner;
  int m_ptr;
  bit m_full;

  // per-input packet sources
  logic [FW-1:0] s_flit[CH];
  bit            s_last[CH];
  bit            s_act[CH];
  int            s_rem[CH];

  logic [CH-1:0] en_mask;
  int v_pct, r_pct, max_len, fix_len;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = CH - 1;
    m_full   = 1'b0;
    for (int i = 0; i < CH; i++) s_act[i] = 1'b0;
    exp_q.delete();
  endtask

  task automatic new_pkt(input int i);
    s_rem[i]  = (fix_len > 0) ? fix_len : int'($urandom_range(1, max_len));
    s_flit[i] = $urandom;
    s_last[i] = (s_rem[i] == 1);
    s_act[i]  = 1'b1;
  endtask

  // Predict this cycle's handshake from the arbitration rules, then advance.
  task automatic model_step();
    logic [CH-1:0] er;
    int  sel;
    bit  load, take;
    chk("locked", locked, m_locked);
    chk("grant", grant, m_locked ? (64'd1 << m_owner) : 64'd0);
    chk("out_valid", out_valid, m_full);
    load = !m_full || out_ready;
    sel  = -1;
    if (m_locked) sel = m_owner;
    else begin
      for (int k = 1; k <= CH; k++) begin
        int j;
        j = (m_ptr + k) % CH;
        if (sel < 0 && in_valid[j]) sel = j;
      end
    end
    er = '0;
    if (sel >= 0 && load) er[sel] = 1'b1;
    chk("in_ready", in_ready, er);
    take = (sel >= 0) && load && in_valid[sel];
    if (m_full && out_ready && !take) m_full = 1'b0;
    if (take) begin
      exp_q.push_back({in_last[sel], in_flit[sel]});
      m_full = 1'b1;
      if (in_last[sel]) begin
        m_locked = 1'b0;
        m_ptr    = sel;
      end else if (!m_locked) begin
        m_locked = 1'b1;
        m_owner  = sel;
      end
      if (s_last[sel]) s_act[sel] = 1'b0;
      else begin
        s_rem[sel]--;
        s_flit[sel] = $urandom;
        s_last[sel] = (s_rem[sel] == 1);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < CH; i++) begin
      if (!s_act[i] && en_mask[i]) new_pkt(i);
      in_valid[i] = s_act[i] && ($urandom_range(0, 99) < v_pct);
      in_flit[i]  = s_act[i] ? s_flit[i] : FW'($urandom);
      in_last[i]  = s_act[i] ? s_last[i] : 1'b0;
    end
    out_ready = ($urandom_range(0, 99) < r_pct);
    #2;
    model_step();
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_flit"}, out_flit, '0);
    chk({tag, "_out_last"}, out_last, 1'b0);
    chk({tag, "_grant"}, grant, '0);
    chk({tag, "_locked"}, locked, 1'b0);
    chk({tag, "_in_ready"}, in_ready, '0);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic async_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midrst");
    model_reset();
    in_valid  = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
  endtask

  // Output-side monitor: pops one expected flit per output transfer.
  always @(negedge clk) begin
    logic [FW:0] e;
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL out_unexpected: got flit %0h expected none", out_flit);
      end else begin
        e = exp_q.pop_front();
        chk("out_flit", out_flit, e[FW-1:0]);
        chk("out_last", out_last, e[FW]);
      end
    end
  end

  initial begin
    rst       = 1'b0;
    in_flit   = '0;
    in_last   = '0;
    in_valid  = {CH{1'b1}};
    out_ready = 1'b0;
    en_mask   = '0;
    v_pct = 100; r_pct = 100; max_len = 4; fix_len = 0;
    model_reset();
    #1 check_reset_outputs("rst");
    in_valid = '0;
    #11 rst = 1'b1;

    // input 2 sends one 3-flit packet
    fix_len = 3; en_mask = CH'(1 << 2);
    step();
    en_mask = '0;
    run(6);

    // inputs 0,3,5 with continuous single-flit packets
    fix_len = 1; en_mask = 7'b0101001;
    run(12);

    // inputs 1 and 4, owner bubbles
    fix_len = 0; max_len = 4; en_mask = 7'b0010010; v_pct = 65;
    run(40);

    // output backpressure on all inputs
    en_mask = '1; v_pct = 90; r_pct = 40;
    run(60);

    // pointer wrap between inputs 6 and 0
    en_mask = 7'b1000001; max_len = 3; v_pct = 100; r_pct = 100;
    run(30);

    // general random traffic
    en_mask = '1; max_len = 5; v_pct = 80; r_pct = 75;
    run(300);

    // reset mid-packet, then restart with everyone requesting
    max_len = 4; fix_len = 4; v_pct = 100; r_pct = 100;
    run(3);
    async_reset();
    fix_len = 0;
    run(40);

    // drain
    en_mask = '0; v_pct = 100; r_pct = 100;
    run(60);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mpsoc_noc_switch_allocator.md
# mpsoc_noc_switch_allocator

Per-output-port switch allocator for the NoC router. It shares one output link among `CHANNELS` input requesters. Arbitration is round-robin at packet granularity: a winner keeps the output until its `last` flit has passed. The granted flit is forwarded through a single-entry output pipeline register. One instance sits behind each router output port, on each virtual channel, between the switch wiring and the output buffer.

## Interface
Parameters:
- `FLIT_WIDTH`, 32, flit payload width in bits.
- `CHANNELS`, 7, number of requesting inputs; must be ≥ 2.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-low reset (0 = reset).
- `in_flit`  input  `[CHANNELS-1:0][FLIT_WIDTH-1:0]`  flit offered by each input.
- `in_last`  input  `[CHANNELS-1:0]`  marks the final flit of the packet on each input.
- `in_valid`  input  `[CHANNELS-1:0]`  request / flit-valid per input.
- `in_ready`  output  `[CHANNELS-1:0]`  per-input accept; at most one bit is high in any cycle.
- `out_flit`  output  `FLIT_WIDTH`  registered flit.
- `out_last`  output  1  registered last marker.
- `out_valid`  output  1  output register holds a flit.
- `out_ready`  input  1  downstream accept.
- `grant`  output  `[CHANNELS-1:0]`  one-hot owner while locked; 0 when idle.
- `locked`  output  1  a multi-flit packet is in progress.

## Operation
- Transfer conditions:
  - Input transfer on input i: `in_valid[i] && in_ready[i]`.
  - Output transfer: `out_valid && out_ready`.
- `load = !out_valid || out_ready`. `load` is the only condition under which the output register may capture a new flit.
- Two-state FSM: IDLE and LOCKED. A round-robin pointer `ptr` holds the index of the last input that completed a packet.
- IDLE:
  - The candidate g is the first input with `in_valid` high, searching from `ptr+1` modulo `CHANNELS` upward.
  - `in_ready[g] = load`; all other `in_ready` bits are 0.
  - Transfer with `in_last=0`: go to LOCKED, `owner<=g`.
  - Transfer with `in_last=1` (single-flit packet): stay IDLE, `ptr<=g`.
  - No valid input: nothing changes.
- LOCKED:
  - Only `owner` is eligible. `in_ready[owner] = load`; other requests are ignored even when the owner is not valid.
  - Transfer with `in_last=1`: go to IDLE, `ptr<=owner`.
  - The owner dropping `in_valid` mid-packet keeps the lock. The result is a bubble, not a release. There is no timeout.
- Output register:
  - On an input transfer, capture `in_flit[g]` / `in_last[g]` and set `out_valid<=1`.
  - On an output transfer with no input transfer, set `out_valid<=0`.
  - Simultaneous output and input transfer: the register is replaced; `out_valid` stays 1.
  - `out_flit` / `out_last` hold their value when not loaded.
- `grant` is registered: it equals one-hot(`owner`) in LOCKED and 0 in IDLE. `locked` is 1 exactly in LOCKED.
- Pointer arithmetic:
  - Index width is `$clog2(CHANNELS)`.
  - `ptr+1` wraps from `CHANNELS-1` to 0. Non-power-of-two `CHANNELS` must never produce an out-of-range index.

## Timing
- Reset values (immediate on `rst` low, independent of `clk`): FSM=IDLE, `ptr=CHANNELS-1` (input 0 has first priority), `owner=0`, `out_valid=0`, `out_flit=0`, `out_last=0`, `grant=0`, `locked=0`, `in_ready=0`.
- Reset asserted mid-packet: the packet is abandoned and the output register is emptied. After reset release, arbitration restarts from input 0.
- Latency: an input flit accepted at edge N appears on `out_*` after edge N, i.e. 1 cycle.
- Throughput: 1 flit/cycle while `out_ready=1`. There is no idle cycle between back-to-back packets from different inputs.
- `in_ready` is combinational from `in_valid`, FSM state, `ptr`, `out_valid` and `out_ready`. It does not depend on `in_flit` or `in_last`.
- Backpressure: with `out_valid=1` and `out_ready=0`, all `in_ready` bits are 0 and every register holds its value.

## Test plan
- Reset, then input 2 sends a 3-flit packet A,B,C with `out_ready=1`:
  - `out_flit` shows A,B,C on consecutive cycles, starting one cycle after the first acceptance.
  - `locked=1` and `grant=0b0000100` during the packet; IDLE follows C.
- Inputs 0, 3 and 5 all valid with single-flit packets, held continuously: grant order is 0,3,5,0,3,5 with one flit per cycle.
- Input 1 locked with a 4-flit packet and input 4 requesting; input 1 deasserts `in_valid` for 2 cycles after flit 2:
  - `in_ready[4]` stays 0 and `out_valid` shows 2 bubble cycles.
  - Input 4 is granted on the cycle after input 1's last flit is accepted.
- Output backpressure: `out_ready=0` for 3 cycles mid-packet. `out_flit` is stable, all `in_ready` bits are 0, and no flit is lost or duplicated when `out_ready` returns to 1.
- Pointer wrap with `CHANNELS=7`: input 6 completes a packet while inputs 0 and 6 request next; input 0 is granted.
- Reset asserted asynchronously mid-packet (between clock edges):
  - All outputs drop to their reset values immediately.
  - After release, input 0's request wins first.
